// File: rtl/button_rate_select_pkg.sv
// Shared definitions for the button-driven blink-rate selector.
//   btn_state_t         : debounce FSM states
//   HALF_PERIOD_W       : width of the half-period output (ms)
//   HP_0..HP_3          : half-period table, 500/250/100/50 ms
//   half_period_lookup  : maps a rate index to its half-period
package button_rate_select_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_QUAL,
    HELD,
    RELEASE_QUAL
  } btn_state_t;

  localparam int unsigned HALF_PERIOD_W = 10;

  localparam logic [HALF_PERIOD_W-1:0] HP_0 = 10'd500;
  localparam logic [HALF_PERIOD_W-1:0] HP_1 = 10'd250;
  localparam logic [HALF_PERIOD_W-1:0] HP_2 = 10'd100;
  localparam logic [HALF_PERIOD_W-1:0] HP_3 = 10'd50;

  function automatic logic [HALF_PERIOD_W-1:0] half_period_lookup(input logic [1:0] idx);
    logic [HALF_PERIOD_W-1:0] hp;
    unique case (idx)
      2'd0:    hp = HP_0;
      2'd1:    hp = HP_1;
      2'd2:    hp = HP_2;
      default: hp = HP_3;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/button_rate_select_tick_gen.sv
// tick_gen: free-running strobe generator, one-cycle pulse every CYCLES clocks.
//   CYCLES : strobe period in clock cycles (>= 1)
//   Clock  : system clock
//   Reset  : asynchronous, active-high
//   Tick   : registered strobe, high in the cycle after the counter hits CYCLES-1
module tick_gen #(
  parameter int unsigned CYCLES = 27000
) (
  input  logic Clock,
  input  logic Reset,
  output logic Tick
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      Tick  <= 1'b0;
    end else begin
      Tick <= (count == TERM);
      if (count == TERM) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/button_rate_select.sv
// button_rate_select: synchronises and debounces a push button and steps a
// blink half-period table on each accepted press.
//   Clock          : system clock
//   Reset          : asynchronous, active-high
//   Button         : raw active-high button level, asynchronous to Clock
//   Tick_1ms       : one-cycle strobe every CLOCK_FREQUENCY/1000 cycles
//   Press_pulse    : one-cycle strobe per accepted press (or long-press action)
//   Rate_index     : current table index 0..3
//   Half_period_ms : registered table lookup of Rate_index (500/250/100/50)
// Optional feature macro: LONG_PRESS_RESET_EN -- holding for LONG_PRESS_MS
// forces Rate_index back to 0 with one extra Press_pulse.
module button_rate_select
  import button_rate_select_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned LONG_PRESS_MS   = 1000
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Button,
  output logic                     Tick_1ms,
  output logic                     Press_pulse,
  output logic [1:0]               Rate_index,
  output logic [HALF_PERIOD_W-1:0] Half_period_ms
);

  localparam int unsigned CYCLES_PER_MS = CLOCK_FREQUENCY / 1000;
  localparam int unsigned DEB           = CYCLES_PER_MS * DEBOUNCE_MS - 1;
  localparam int unsigned DEB_W         = (DEB > 0) ? $clog2(DEB + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_TERM = DEB_W'(DEB);

  // Two-flop synchroniser
  logic btn_m, btn_s;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= Button;
      btn_s <= btn_m;
    end
  end

  tick_gen #(.CYCLES(CYCLES_PER_MS)) u_tick_gen (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick_1ms)
  );

  btn_state_t       state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             press_d;
  logic [1:0]       rate_d;

`ifdef LONG_PRESS_RESET_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_MS + 1);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LONG_PRESS_MS);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              lp_done_q, lp_done_d;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      Press_pulse <= 1'b0;
      Rate_index  <= '0;
`ifdef LONG_PRESS_RESET_EN
      hold_q      <= '0;
      lp_done_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      Press_pulse <= press_d;
      Rate_index  <= rate_d;
`ifdef LONG_PRESS_RESET_EN
      hold_q      <= hold_d;
      lp_done_q   <= lp_done_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    press_d = 1'b0;
    rate_d  = Rate_index;
`ifdef LONG_PRESS_RESET_EN
    hold_d    = hold_q;
    lp_done_d = lp_done_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_QUAL;
          deb_d   = '0;
        end
      end
      PRESS_QUAL: begin
        if (!btn_s) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_TERM) begin
          state_d = HELD;
          deb_d   = '0;
          press_d = 1'b1;
          rate_d  = Rate_index + 2'd1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_QUAL;
          deb_d   = '0;
        end
      end
      RELEASE_QUAL: begin
        if (btn_s) begin
          state_d = HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_TERM) begin
          state_d = IDLE;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        deb_d   = '0;
      end
    endcase

`ifdef LONG_PRESS_RESET_EN
    // Hold counter advances on ms ticks while HELD; the action fires once,
    // even if the button drops in the same cycle.
    if (state_q == HELD) begin
      if (!lp_done_q && hold_q == HOLD_TERM) begin
        press_d   = 1'b1;
        rate_d    = '0;
        lp_done_d = 1'b1;
      end else if (Tick_1ms && !lp_done_q) begin
        hold_d = hold_q + 1'b1;
      end
    end
    if (state_d != HELD) begin
      hold_d    = '0;
      lp_done_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) Half_period_ms <= HP_0;
    else       Half_period_ms <= half_period_lookup(Rate_index);
  end

endmodule

// File: tb/tb_button_rate_select.sv
module tb_button_rate_select;

  localparam int CF     = 10000;
  localparam int DEB_MS = 2;
  localparam int LP_MS  = 5;
  localparam int CPM    = CF / 1000;        // 10 cycles per ms
  localparam int ACCEPT = CPM * DEB_MS + 1; // consecutive btn_s samples to accept a level (DEB+2 = 21)

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Button = 1'b0;
  logic       Tick_1ms;
  logic       Press_pulse;
  logic [1:0] Rate_index;
  logic [9:0] Half_period_ms;

  button_rate_select #(
    .CLOCK_FREQUENCY (CF),
    .DEBOUNCE_MS     (DEB_MS),
    .LONG_PRESS_MS   (LP_MS)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Button         (Button),
    .Tick_1ms       (Tick_1ms),
    .Press_pulse    (Press_pulse),
    .Rate_index     (Rate_index),
    .Half_period_ms (Half_period_ms)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int hp_table [4] = '{500, 250, 100, 50};

  // Behavioural model: a level is accepted after ACCEPT consecutive samples
  // differing from the currently accepted level; sampled Button reaches the
  // debouncer two edges later.
  int   m_edge;
  logic h1, h2;
  logic m_acc;
  int   m_run;
  int   m_idx;
  logic m_pulse;
  logic m_tick_prev;
  int   m_hc;
  logic m_done;

  task automatic model_reset();
    m_edge = 0; h1 = 0; h2 = 0; m_acc = 0; m_run = 0; m_idx = 0;
    m_pulse = 0; m_tick_prev = 0; m_hc = 0; m_done = 0;
  endtask

  task automatic model_step(input logic s, input logic t);
    m_pulse = 0;
`ifdef LONG_PRESS_RESET_EN
    if (m_acc && m_run == 0) begin
      if (!m_done && m_hc == LP_MS) begin
        m_idx = 0; m_pulse = 1; m_done = 1;
      end else if (t && !m_done) begin
        m_hc++;
      end
    end
`endif
    if (s == m_acc) m_run = 0;
    else begin
      m_run++;
      if (m_run == ACCEPT) begin
        m_acc = s;
        m_run = 0;
        if (s) begin
          m_idx = (m_idx + 1) % 4;
          m_pulse = 1;
        end
      end
    end
    if (!(m_acc && m_run == 0)) begin
      m_hc = 0; m_done = 0;
    end
  endtask

  // Observation counters for directed checks
  int cyc = 0;
  int press_cnt = 0;
  int tick_cnt = 0;
  int last_press_cyc = -1;

  logic bs, rs, cur;
  int   idx_before;

  initial model_reset();

  // Single compare process, sampling #1 after each rising edge
  always @(posedge Clock) begin
    bs = Button;
    rs = Reset;
    #1;
    cyc++;
    if (rs) begin
      model_reset();
      check("rst_tick",  Tick_1ms, 0);
      check("rst_press", Press_pulse, 0);
      check("rst_index", Rate_index, 0);
      check("rst_half",  Half_period_ms, 500);
    end else begin
      m_edge++;
      cur = h2; h2 = h1; h1 = bs;
      idx_before = m_idx;
      model_step(cur, m_tick_prev);
      m_tick_prev = (m_edge % CPM == 0);
      check("tick",  Tick_1ms, m_tick_prev);
      check("press", Press_pulse, m_pulse);
      check("index", Rate_index, m_idx);
      check("half",  Half_period_ms, hp_table[idx_before]);
    end
    if (Press_pulse) begin
      press_cnt++;
      last_press_cyc = cyc;
    end
    if (Tick_1ms) tick_cnt++;
  end

  int rise_cyc = 0;
  int pc0;
  int exp_idx [5] = '{1, 2, 3, 0, 1};
  int exp_hp  [5] = '{250, 100, 50, 500, 250};
  logic lvl;

  // Called at a falling edge; the level is seen by the next n rising edges.
  task automatic hold(input logic l, input int n);
    if (l && !Button) rise_cyc = cyc + 1;
    Button = l;
    repeat (n) @(negedge Clock);
  endtask

  task automatic pulse_reset(input int n);
    Reset = 1'b1;
    repeat (n) @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    // Idle: ticks every 10 cycles, no press
    tick_cnt = 0;
    pc0 = press_cnt;
    hold(0, 100);
    check("idle_ticks", tick_cnt, 10);
    check("idle_press", press_cnt - pc0, 0);
    check("idle_half", Half_period_ms, 500);

    // Single clean press
    pc0 = press_cnt;
    hold(1, 40);
    hold(0, 40);
    check("press1_count", press_cnt - pc0, 1);
    check("press1_latency", last_press_cyc - rise_cyc, 22);
    check("press1_index", Rate_index, 1);
    check("press1_half", Half_period_ms, 250);

    // Bouncing then settled press
    pc0 = press_cnt;
    for (int i = 0; i < 4; i++) begin
      hold(1, 5);
      hold(0, 3);
    end
    hold(1, 30);
    hold(0, 30);
    check("bounce_count", press_cnt - pc0, 1);
    check("bounce_latency", last_press_cyc - rise_cyc, 22);
    check("bounce_index", Rate_index, 2);

    // Five clean presses from reset
    pulse_reset(2);
    hold(0, 5);
    for (int i = 0; i < 5; i++) begin
      hold(1, 30);
      hold(0, 30);
      check("seq_index", Rate_index, exp_idx[i]);
      check("seq_half", Half_period_ms, exp_hp[i]);
    end

    // Reset in the middle of qualification while the button stays high
    pulse_reset(2);
    hold(0, 5);
    pc0 = press_cnt;
    hold(1, 10);
    check("rstq_no_press", press_cnt - pc0, 0);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    rise_cyc = cyc + 1;
    repeat (39) @(negedge Clock);
    hold(0, 30);
    check("rstq_count", press_cnt - pc0, 1);
    check("rstq_latency", last_press_cyc - rise_cyc, 22);
    check("rstq_index", Rate_index, 1);

`ifdef LONG_PRESS_RESET_EN
    // Long press from index 2: press to 3, then forced back to 0
    pulse_reset(2);
    hold(0, 5);
    hold(1, 30); hold(0, 30);
    hold(1, 30); hold(0, 30);
    check("lp_start_index", Rate_index, 2);
    pc0 = press_cnt;
    hold(1, 80);
    hold(0, 30);
    check("lp_count", press_cnt - pc0, 2);
    check("lp_index", Rate_index, 0);
`endif

    // Randomised runs against the model
    lvl = 1'b0;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
      if ($urandom_range(0, 3) != 0) lvl = ~lvl;
      hold(lvl, $urandom_range(1, 45));
    end
    hold(0, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
